// File: rtl/netlist_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// netlist_bist_ctrl_if
//
// Bundles the control, stimulus, response and result signals of the netlist
// BIST controller.
//
// Signals
//   start, abort      : run control from the result-capture side
//   dut_in            : stimulus vector driven to both netlist channels
//   out_a, out_b      : golden (A) and candidate (B) netlist responses
//   busy, done        : run status
//   sig_a, sig_b      : MISR signatures of channel A and channel B
//   mismatch          : sticky disagreement flag
//   fail_idx, fail_vec: index and stimulus vector of the first disagreement
//
// Modports
//   master : the BIST controller (drives stimulus and results)
//   slave  : the environment (drives run control and netlist responses)
// -----------------------------------------------------------------------------
interface netlist_bist_ctrl_if #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 8
);
    logic             start;
    logic             abort;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] out_a;
    logic [OUT_W-1:0] out_b;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] sig_a;
    logic [OUT_W-1:0] sig_b;
    logic             mismatch;
    logic [19:0]      fail_idx;
    logic [IN_W-1:0]  fail_vec;

    modport master (
        input  start, abort, out_a, out_b,
        output dut_in, busy, done, sig_a, sig_b, mismatch, fail_idx, fail_vec
    );

    modport slave (
        output start, abort, out_a, out_b,
        input  dut_in, busy, done, sig_a, sig_b, mismatch, fail_idx, fail_vec
    );
endinterface

// File: rtl/netlist_bist_ctrl.sv
// -----------------------------------------------------------------------------
// netlist_bist_ctrl
//
// Two-channel BIST controller for combinational netlists. An LFSR produces
// NUM_PAT input vectors that are driven to the golden netlist (channel A) and
// the optimised candidate (channel B) at the same time. The responses of each
// channel are compacted into a MISR signature, and the first pattern on which
// the two channels disagree is recorded. Register stages inside the netlist
// wrapper (DUT_LAT) are matched by an internal delay line so every response
// is paired with the vector that produced it.
//
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset
//   bist : netlist_bist_ctrl_if master modport
//          in : start, abort, out_a, out_b
//          out: dut_in, busy, done, sig_a, sig_b, mismatch, fail_idx, fail_vec
//
// All outputs are registered; out_a/out_b only reach registers.
// -----------------------------------------------------------------------------
module netlist_bist_ctrl #(
    parameter int               IN_W      = 14,
    parameter int               OUT_W     = 8,
    parameter int               NUM_PAT   = 1024,
    parameter int               DUT_LAT   = 0,
    parameter logic [IN_W-1:0]  SEED      = {{(IN_W-1){1'b0}}, 1'b1},
    parameter logic [IN_W-1:0]  LFSR_TAPS = IN_W'(14'h2015),
    parameter logic [OUT_W-1:0] MISR_TAPS = OUT_W'(8'hB8)
) (
    input logic                 clk,
    input logic                 rst,
    netlist_bist_ctrl_if.master bist
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
    localparam logic [IN_W-1:0] SEED_EFF   = (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;
    localparam logic [19:0]     PAT_LAST   = 20'(NUM_PAT - 1);
    localparam logic [1:0]      DRAIN_LAST = (DUT_LAT > 0) ? 2'(DUT_LAT - 1) : 2'd0;

    // Fibonacci-style LFSR step: shift left, feedback is parity of tapped bits.
    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] cur);
        return {cur[IN_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    // MISR step: LFSR shift with the channel response folded in.
    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] cur,
                                                   input logic [OUT_W-1:0] din);
        return {cur[OUT_W-2:0], ^(cur & MISR_TAPS)} ^ din;
    endfunction

    state_t           state_q;
    logic [IN_W-1:0]  lfsr_q;       // next vector to be issued
    logic [19:0]      cnt_q;        // index of the vector currently on dut_in
    logic [1:0]       drain_cnt_q;
    logic [IN_W-1:0]  dut_in_q;
    logic             busy_q;
    logic             done_q;
    logic [OUT_W-1:0] sig_a_q;
    logic [OUT_W-1:0] sig_b_q;
    logic             mismatch_q;
    logic [19:0]      fail_idx_q;
    logic [IN_W-1:0]  fail_vec_q;

    logic [OUT_W-1:0] sig_a_d;
    logic [OUT_W-1:0] sig_b_d;
    logic             issue_valid_s;
    logic             sample_valid_s;
    logic [19:0]      sample_idx_s;
    logic [IN_W-1:0]  sample_vec_s;
    logic             sample_en_s;
    logic             first_fail_s;

    assign issue_valid_s = (state_q == ST_RUN);
    // busy_q gates sampling so nothing can update results outside a run.
    assign sample_en_s   = sample_valid_s & busy_q;

    generate
        if (DUT_LAT == 0) begin : g_no_lat
            // Purely combinational netlist: the response belongs to the current vector.
            assign sample_valid_s = issue_valid_s;
            assign sample_idx_s   = cnt_q;
            assign sample_vec_s   = dut_in_q;
        end else begin : g_lat
            logic [DUT_LAT-1:0] vld_pipe_q;
            logic [19:0]        idx_pipe_q [DUT_LAT];
            logic [IN_W-1:0]    vec_pipe_q [DUT_LAT];

            // Delay line matching the wrapper registers; abort flushes it so a stale sample never lands in a new run.
            always_ff @(posedge clk) begin
                if (rst || bist.abort) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        vld_pipe_q[i] <= 1'b0;
                        idx_pipe_q[i] <= '0;
                        vec_pipe_q[i] <= '0;
                    end
                end else begin
                    vld_pipe_q[0] <= issue_valid_s;
                    idx_pipe_q[0] <= cnt_q;
                    vec_pipe_q[0] <= dut_in_q;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_pipe_q[i] <= vld_pipe_q[i-1];
                        idx_pipe_q[i] <= idx_pipe_q[i-1];
                        vec_pipe_q[i] <= vec_pipe_q[i-1];
                    end
                end
            end

            assign sample_valid_s = vld_pipe_q[DUT_LAT-1];
            assign sample_idx_s   = idx_pipe_q[DUT_LAT-1];
            assign sample_vec_s   = vec_pipe_q[DUT_LAT-1];
        end
    endgenerate

    // Next MISR values and first-disagreement detection for the sample in flight.
    always_comb begin
        sig_a_d = misr_step(sig_a_q, bist.out_a);
        sig_b_d = misr_step(sig_b_q, bist.out_b);
        if (sample_en_s && (bist.out_a != bist.out_b) && !mismatch_q) begin
            first_fail_s = 1'b1;
        end else begin
            first_fail_s = 1'b0;
        end
    end

    // Run FSM with stimulus generation, response compaction and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED_EFF;
            cnt_q       <= 20'd0;
            drain_cnt_q <= 2'd0;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sig_a_q     <= '0;
            sig_b_q     <= '0;
            mismatch_q  <= 1'b0;
            fail_idx_q  <= 20'd0;
            fail_vec_q  <= '0;
        end else if (bist.abort) begin
            // Results and dut_in freeze; only the control state returns to idle.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (sample_en_s) begin
                sig_a_q <= sig_a_d;
                sig_b_q <= sig_b_d;
            end
            if (first_fail_s) begin
                mismatch_q <= 1'b1;
                fail_idx_q <= sample_idx_s;
                fail_vec_q <= sample_vec_s;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bist.start) begin
                        // The seed goes straight onto dut_in; lfsr_q runs one vector ahead.
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        cnt_q       <= 20'd0;
                        drain_cnt_q <= 2'd0;
                        dut_in_q    <= SEED_EFF;
                        lfsr_q      <= lfsr_step(SEED_EFF);
                        sig_a_q     <= '0;
                        sig_b_q     <= '0;
                        mismatch_q  <= 1'b0;
                        fail_idx_q  <= 20'd0;
                        fail_vec_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == PAT_LAST) begin
                        if (DUT_LAT == 0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= 2'd0;
                        end
                    end else begin
                        cnt_q    <= cnt_q + 20'd1;
                        dut_in_q <= lfsr_q;
                        lfsr_q   <= lfsr_step(lfsr_q);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bist.dut_in   = dut_in_q;
    assign bist.busy     = busy_q;
    assign bist.done     = done_q;
    assign bist.sig_a    = sig_a_q;
    assign bist.sig_b    = sig_b_q;
    assign bist.mismatch = mismatch_q;
    assign bist.fail_idx = fail_idx_q;
    assign bist.fail_vec = fail_vec_q;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_netlist_bist_ctrl
//
// Two controllers run side by side from the same start/abort stimulus: one
// with a combinational netlist pair (DUT_LAT=0) and one with a two-stage
// registered pass-through wrapper (DUT_LAT=2). Both use NUM_PAT=4, SEED=1.
// Channel A returns dut_in[7:0]; channel B returns the same, optionally with
// bit 0 flipped when the vector is 0x0007.
// -----------------------------------------------------------------------------
module tb_netlist_bist_ctrl;
    localparam int IN_W    = 14;
    localparam int OUT_W   = 8;
    localparam int NUM_PAT = 4;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        mismatch;
        logic [7:0]  sig_a;
        logic [7:0]  sig_b;
        logic [19:0] fail_idx;
        logic [13:0] fail_vec;
        logic [13:0] dut_in;
    } obs_t;

    typedef struct packed {
        logic [7:0]  sig_a;
        logic [7:0]  sig_b;
        logic        mm;
        logic [19:0] idx;
        logic [13:0] vec;
        logic [13:0] last;
    } res_t;

    typedef struct {
        string name;
        bit    inject;
        int    abort_cyc;
        int    busy_start_cyc;
        int    exp_busy0;
        int    exp_done0;
        int    exp_busy2;
        int    exp_done2;
    } case_t;

    logic clk = 1'b0;
    logic rst;
    logic start_s;
    logic abort_s;
    logic inject_s;

    int checks = 0;
    int errors = 0;

    logic [13:0] vec_q [$];
    res_t        res_q [$];
    case_t       cases [5];

    always #5 clk = ~clk;

    netlist_bist_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if0 ();
    netlist_bist_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if2 ();

    assign if0.start = start_s;
    assign if0.abort = abort_s;
    assign if2.start = start_s;
    assign if2.abort = abort_s;

    // Combinational netlist pair for the latency-0 controller.
    assign if0.out_a = if0.dut_in[7:0];
    assign if0.out_b = if0.dut_in[7:0] ^ {7'd0, (inject_s && (if0.dut_in == 14'h0007))};

    // Two-stage registered pass-through wrapper for the latency-2 controller.
    logic [13:0] p1 = 14'd0;
    logic [13:0] p2 = 14'd0;
    always @(posedge clk) begin
        p1 <= if2.dut_in;
        p2 <= p1;
    end
    assign if2.out_a = p2[7:0];
    assign if2.out_b = p2[7:0] ^ {7'd0, (inject_s && (p2 == 14'h0007))};

    netlist_bist_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_PAT(NUM_PAT), .DUT_LAT(0),
                        .SEED(14'h0001), .LFSR_TAPS(14'h2015), .MISR_TAPS(8'hB8))
        dut0 (.clk(clk), .rst(rst), .bist(if0));

    netlist_bist_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_PAT(NUM_PAT), .DUT_LAT(2),
                        .SEED(14'h0001), .LFSR_TAPS(14'h2015), .MISR_TAPS(8'hB8))
        dut2 (.clk(clk), .rst(rst), .bist(if2));

    obs_t obs [2];
    assign obs[0] = {if0.busy, if0.done, if0.mismatch, if0.sig_a, if0.sig_b,
                     if0.fail_idx, if0.fail_vec, if0.dut_in};
    assign obs[1] = {if2.busy, if2.done, if2.mismatch, if2.sig_a, if2.sig_b,
                     if2.fail_idx, if2.fail_vec, if2.dut_in};

    function automatic logic [13:0] m_lfsr(input logic [13:0] l);
        return {l[12:0], ^(l & 14'h2015)};
    endfunction

    function automatic logic [7:0] m_misr(input logic [7:0] m, input logic [7:0] d);
        return {m[6:0], ^(m & 8'hB8)} ^ d;
    endfunction

    // Expected results after the first nsamp patterns have been sampled.
    function automatic res_t model(input bit inj, input int nsamp);
        res_t        r;
        logic [13:0] l;
        logic [7:0]  oa;
        logic [7:0]  ob;
        r = '0;
        l = 14'h0001;
        for (int k = 0; k < nsamp; k++) begin
            oa = l[7:0];
            ob = oa ^ {7'd0, (inj && (l == 14'h0007))};
            r.sig_a = m_misr(r.sig_a, oa);
            r.sig_b = m_misr(r.sig_b, ob);
            if ((oa != ob) && !r.mm) begin
                r.mm  = 1'b1;
                r.idx = 20'(k);
                r.vec = l;
            end
            r.last = l;
            l = m_lfsr(l);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one table row on both controllers; caller is positioned at a negedge.
    task automatic run_case(input case_t c);
        res_t        r;
        res_t        fr;
        res_t        got;
        logic [13:0] l;
        logic [13:0] e;
        int          bcnt [2];
        int          dcyc [2];
        int          issued;
        int          ns;
        string       dn;

        r      = model(c.inject, NUM_PAT);
        issued = (c.abort_cyc != 0 && c.abort_cyc < NUM_PAT) ? c.abort_cyc : NUM_PAT;
        l      = 14'h0001;
        for (int k = 0; k < issued; k++) begin
            vec_q.push_back(l);
            l = m_lfsr(l);
        end
        if (c.abort_cyc == 0) begin
            res_q.push_back(r);
            res_q.push_back(r);
        end
        bcnt     = '{0, 0};
        dcyc     = '{0, 0};
        inject_s = c.inject;
        start_s  = 1'b1;

        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start_s = 1'b0;
            abort_s = 1'b0;
            if (cyc == 1) begin
                for (int d = 0; d < 2; d++) begin
                    dn = $sformatf("%s/dut%0d", c.name, d * 2);
                    check({dn, "/first_run_mismatch"}, 32'(obs[d].mismatch), 32'd0);
                    check({dn, "/first_run_sig_a"}, 32'(obs[d].sig_a), 32'd0);
                end
            end
            if (obs[0].busy && bcnt[0] < NUM_PAT) begin
                check({c.name, "/vec_expected"}, 32'(vec_q.size() != 0), 32'd1);
                if (vec_q.size() != 0) begin
                    e = vec_q.pop_front();
                    check($sformatf("%s/dut0/dut_in[%0d]", c.name, bcnt[0]), 32'(obs[0].dut_in), 32'(e));
                    check($sformatf("%s/dut2/dut_in[%0d]", c.name, bcnt[0]), 32'(obs[1].dut_in), 32'(e));
                end
            end
            for (int d = 0; d < 2; d++) begin
                dn = $sformatf("%s/dut%0d", c.name, d * 2);
                if (obs[d].busy) bcnt[d]++;
                if (obs[d].done && dcyc[d] == 0) begin
                    dcyc[d] = cyc;
                    check({dn, "/done_expected"}, 32'(res_q.size() != 0), 32'd1);
                    if (res_q.size() != 0) begin
                        got = res_q.pop_front();
                        check({dn, "/sig_a"},    32'(obs[d].sig_a),    32'(got.sig_a));
                        check({dn, "/sig_b"},    32'(obs[d].sig_b),    32'(got.sig_b));
                        check({dn, "/mismatch"}, 32'(obs[d].mismatch), 32'(got.mm));
                        check({dn, "/fail_idx"}, 32'(obs[d].fail_idx), 32'(got.idx));
                        check({dn, "/fail_vec"}, 32'(obs[d].fail_vec), 32'(got.vec));
                        check({dn, "/dut_in_hold"}, 32'(obs[d].dut_in), 32'(got.last));
                    end
                end
                if (c.abort_cyc != 0 && cyc == c.abort_cyc + 1) begin
                    check({dn, "/abort_busy"}, 32'(obs[d].busy), 32'd0);
                    check({dn, "/abort_done"}, 32'(obs[d].done), 32'd0);
                end
                if (cyc == 12) begin
                    if (c.abort_cyc != 0) begin
                        ns = c.abort_cyc - 1 - d * 2;
                        if (ns < 0) ns = 0;
                        fr = model(c.inject, ns);
                        check({dn, "/frozen_sig_a"},    32'(obs[d].sig_a),    32'(fr.sig_a));
                        check({dn, "/frozen_sig_b"},    32'(obs[d].sig_b),    32'(fr.sig_b));
                        check({dn, "/frozen_mismatch"}, 32'(obs[d].mismatch), 32'(fr.mm));
                    end else begin
                        check({dn, "/done_stable"},  32'(obs[d].done),  32'd1);
                        check({dn, "/sig_a_stable"}, 32'(obs[d].sig_a), 32'(r.sig_a));
                    end
                end
            end
            start_s = (cyc == c.busy_start_cyc);
            abort_s = (cyc == c.abort_cyc);
        end

        check({c.name, "/dut0/busy_cycles"}, 32'(bcnt[0]), 32'(c.exp_busy0));
        check({c.name, "/dut0/done_cycle"},  32'(dcyc[0]), 32'(c.exp_done0));
        check({c.name, "/dut2/busy_cycles"}, 32'(bcnt[1]), 32'(c.exp_busy2));
        check({c.name, "/dut2/done_cycle"},  32'(dcyc[1]), 32'(c.exp_done2));
        check({c.name, "/vec_leftover"}, 32'(vec_q.size()), 32'd0);
        check({c.name, "/res_leftover"}, 32'(res_q.size()), 32'd0);
        vec_q.delete();
        res_q.delete();
    endtask

    initial begin
        res_t  pass_r;
        string dn;

        rst      = 1'b1;
        start_s  = 1'b0;
        abort_s  = 1'b0;
        inject_s = 1'b0;
        pass_r   = model(1'b0, NUM_PAT);

        // name, inject, abort_cyc, busy_start_cyc, busy0, done0, busy2, done2
        cases[0] = '{"pass",          1'b0, 0, 0, 4, 5, 6, 7};
        cases[1] = '{"fail_capture",  1'b1, 0, 0, 4, 5, 6, 7};
        cases[2] = '{"start_in_busy", 1'b0, 0, 2, 4, 5, 6, 7};
        cases[3] = '{"abort",         1'b0, 2, 0, 2, 0, 2, 0};
        cases[4] = '{"restart",       1'b0, 0, 0, 4, 5, 6, 7};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            dn = $sformatf("reset/dut%0d", d * 2);
            check({dn, "/busy"},     32'(obs[d].busy),     32'd0);
            check({dn, "/done"},     32'(obs[d].done),     32'd0);
            check({dn, "/dut_in"},   32'(obs[d].dut_in),   32'd0);
            check({dn, "/sig_a"},    32'(obs[d].sig_a),    32'd0);
            check({dn, "/sig_b"},    32'(obs[d].sig_b),    32'd0);
            check({dn, "/mismatch"}, 32'(obs[d].mismatch), 32'd0);
            check({dn, "/fail_idx"}, 32'(obs[d].fail_idx), 32'd0);
            check({dn, "/fail_vec"}, 32'(obs[d].fail_vec), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            dn = $sformatf("idle/dut%0d", d * 2);
            check({dn, "/busy"}, 32'(obs[d].busy), 32'd0);
            check({dn, "/done"}, 32'(obs[d].done), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            run_case(cases[i]);
        end

        // start and abort together while in DONE: abort wins, results stay frozen.
        start_s = 1'b1;
        abort_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        abort_s = 1'b0;
        for (int d = 0; d < 2; d++) begin
            dn = $sformatf("start_abort/dut%0d", d * 2);
            check({dn, "/busy"},  32'(obs[d].busy),  32'd0);
            check({dn, "/done"},  32'(obs[d].done),  32'd0);
            check({dn, "/sig_a"}, 32'(obs[d].sig_a), 32'(pass_r.sig_a));
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            dn = $sformatf("start_abort_idle/dut%0d", d * 2);
            check({dn, "/busy"}, 32'(obs[d].busy), 32'd0);
            check({dn, "/done"}, 32'(obs[d].done), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/netlist_bist_ctrl.md
# netlist_bist_ctrl

Parametrised built-in self-test controller for the optimised combinational netlists produced by the genetic-algorithm flow. It drives one input vector to two netlist channels at a time: the golden netlist (channel A) and the optimised candidate (channel B). Vectors come from an LFSR. The block compacts each channel's outputs into a MISR signature and records the first pattern where the two channels disagree. It sits between the netlist-under-test wrapper and the flow's result-capture logic. It replaces open-loop, exhaustive stimulus with a counted, latency-aware, two-channel compare.

## Interface
- IN_W, 14: netlist input width and LFSR width; legal range 2..32.
- OUT_W, 8: netlist output width and MISR width; legal range 2..32.
- NUM_PAT, 1024: number of patterns applied per run; legal range 1..2^20.
- DUT_LAT, 0: register stages inside the netlist wrapper; legal range 0..3.
- SEED, 14'h0001: first LFSR state. A value of 0 is replaced by 1.
- LFSR_TAPS, 14'h2015: feedback mask for the LFSR (bits 13,4,2,0).
- MISR_TAPS, 8'hB8: feedback mask for the MISR.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset; synchronous, active-high.
- start, in, 1: begins a run. Sampled only in IDLE or DONE.
- abort, in, 1: synchronous abort of a run; returns the block to IDLE.
- dut_in, out, IN_W: vector driven to both channels.
- out_a, in, OUT_W: golden netlist outputs.
- out_b, in, OUT_W: candidate netlist outputs.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: high while in DONE.
- sig_a, out, OUT_W: MISR signature of channel A.
- sig_b, out, OUT_W: MISR signature of channel B.
- mismatch, out, 1: sticky flag; set when out_a != out_b on any sampled pattern.
- fail_idx, out, 20: 0-based index of the first mismatching pattern.
- fail_vec, out, IN_W: dut_in value of the first mismatching pattern.

## Operation
State machine: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on start.
- RUN to DRAIN after NUM_PAT patterns have been issued. RUN goes directly to DONE when DUT_LAT=0.
- DRAIN to DONE after DUT_LAT cycles.
- DONE to RUN on start.
- Any state to IDLE on abort. rst overrides abort.

Reset and run-start behaviour:
- On reset, every output is 0, the LFSR holds SEED, and the state is IDLE.
- Entering RUN from IDLE or DONE clears sig_a, sig_b, mismatch, fail_idx and fail_vec, reloads the LFSR with SEED, and clears the pattern counter.

Stimulus:
- In RUN cycle k (k = 0..NUM_PAT-1), dut_in = LFSR state and issue_valid = 1.
- LFSR step: next = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}.
- dut_in holds its last value outside RUN.

Sampling:
- issue_valid and the pattern index are delayed DUT_LAT cycles to form sample_valid and sample_idx. The dut_in value is delayed the same way to form sample_vec.
- When sample_valid is high, each MISR updates: misr_next = {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ out_x.
- On the first sample where out_a != out_b: mismatch is set, and fail_idx and fail_vec capture sample_idx and sample_vec. Later mismatches do not update these fields.

Boundary rules:
- start is ignored while busy.
- abort during RUN or DRAIN freezes sig_a, sig_b and the fail fields at their current values. done stays 0. A subsequent start clears them.
- start and abort in the same cycle: abort wins.
- NUM_PAT=1 gives exactly one RUN cycle.
- All arithmetic is modulo the stated widths.

## Timing
- Cycle 0: start is sampled. RUN occupies cycles 1..NUM_PAT.
- DRAIN occupies the next DUT_LAT cycles. done rises on cycle NUM_PAT+DUT_LAT+1.
- busy covers exactly the RUN and DRAIN cycles.
- The MISR update and mismatch capture for pattern k land on the clock edge at the end of cycle 1+k+DUT_LAT. Their results are visible in the following cycle.
- sig_a, sig_b, mismatch, fail_idx and fail_vec are final and stable while done=1.
- No combinational path from out_a or out_b to any output.

## Test plan
- Reset: assert rst for 2 cycles with no start. Required: all outputs 0, busy=0, done=0, state IDLE.
- Pass run: SEED=1, NUM_PAT=4, DUT_LAT=0, out_a = out_b = dut_in[7:0]. Required: dut_in sequence 0x0001, 0x0003, 0x0007, 0x000E; sig_a = sig_b = 0x04; mismatch=0; busy high for 4 cycles; done rises 5 cycles after start.
- Fail capture: same as the pass run, but out_b = out_a ^ 1 only when dut_in = 0x0007. Required: mismatch=1, fail_idx=2, fail_vec=0x0007, sig_a=0x04, sig_b != sig_a.
- Latency alignment: DUT_LAT=2, with a 2-stage registered pass-through wrapper. Required: same signatures as the pass run; busy for 6 cycles; done 7 cycles after start.
- Abort and restart: abort in the second RUN cycle. Required: IDLE next cycle, done=0. A following start reproduces the pass-run results exactly.
- Start handling: start while busy is ignored. start pulsed in DONE restarts the run and clears mismatch on the first RUN cycle.
